// File: rtl/iter_alu_pkg.sv
// Shared opcode and FSM state types for the iterative ALU.
package iter_alu_pkg;

   typedef enum logic [2:0] {
      OP_PAR     = 3'b000,
      OP_SHL     = 3'b001,
      OP_SHR     = 3'b010,
      OP_CMP     = 3'b011,
      OP_HALFSET = 3'b100,
      OP_AND     = 3'b101,
      OP_MUL     = 3'b110,
      OP_ADD     = 3'b111
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/iter_alu_single.sv
// Combinational evaluation of the ops that complete in the start cycle.
// Shift opcodes fall through to a pass-through of A, which is exactly the
// result required for a zero-amount shift.
module alu_single
   import iter_alu_pkg::*;
#(
   parameter int W = 8
) (
   input  alu_op_t          i_op,
   input  logic [W-1:0]     i_a,
   input  logic [W-1:0]     i_b,
   input  logic [W-1:0]     i_in0,
   input  logic [W/2-1:0]   i_immed,
   input  logic             i_sc_in,
   output logic [W-1:0]     o_rslt,
   output logic             o_sc_o,
   output logic             o_notequal,
   output logic             o_lessthan
);

   logic [W:0] w_sum;

   assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_sc_in};

   // Result and flag selection; unproduced flags default to 0.
   always_comb begin
      o_rslt     = i_a;
      o_sc_o     = 1'b0;
      o_notequal = 1'b0;
      o_lessthan = 1'b0;
      case (i_op)
         OP_PAR:     o_rslt = {{(W-1){1'b0}}, ^i_a};
         OP_CMP: begin
            o_rslt     = '0;
            o_notequal = (i_a != i_b);
            o_lessthan = (i_a < i_b);
         end
         OP_HALFSET: o_rslt = {i_in0[W/2-1:0], i_immed};
         OP_AND:     o_rslt = i_a & i_b;
         OP_ADD:     {o_sc_o, o_rslt} = w_sum;
         default:    o_rslt = i_a;
      endcase
   end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle ALU: single-cycle ops finish in the start cycle, shifts and
// shift-add multiply iterate one step per cycle while busy is high.
module iter_alu
   import iter_alu_pkg::*;
#(
   parameter int W    = 8,
   parameter int SH_W = $clog2(W) + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [W-1:0]     i_in_a,
   input  logic [W-1:0]     i_in_b,
   input  logic [W-1:0]     i_in_0,
   input  logic [W/2-1:0]   i_immed,
   input  logic             i_sc_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [W-1:0]     o_rslt,
   output logic             o_sc_o,
   output logic             o_notequal,
   output logic             o_lessthan
);

   localparam logic [SH_W-1:0] W_SH = SH_W'(W);

   state_t              r_state, w_state_next;
   alu_op_t             r_op;
   logic [SH_W-1:0]     r_count;
   logic [W-1:0]        r_a;       // shift register for SHL/SHR
   logic [W-1:0]        r_b;       // multiplier, consumed LSB first
   logic [2*W-1:0]      r_mcand;   // multiplicand, moves left each step
   logic [2*W-1:0]      r_acc;     // partial product
   logic                r_fill;
   logic                r_done;
   logic [W-1:0]        r_rslt;
   logic                r_sc_o, r_notequal, r_lessthan;

   alu_op_t             w_op;
   logic [SH_W-1:0]     w_k_raw, w_k;
   logic                w_is_shift, w_launch, w_last;
   logic [W-1:0]        w_sh_val;
   logic                w_sh_out;
   logic [2*W-1:0]      w_acc_next;
   logic [W-1:0]        w_s_rslt;
   logic                w_s_sc_o, w_s_ne, w_s_lt;

   assign w_op       = alu_op_t'(i_op);
   assign w_k_raw    = i_in_b[SH_W-1:0];
   assign w_k        = (w_k_raw > W_SH) ? W_SH : w_k_raw;
   assign w_is_shift = (w_op == OP_SHL) || (w_op == OP_SHR);
   assign w_launch   = (w_op == OP_MUL) || (w_is_shift && (w_k != '0));
   assign w_last     = (r_count == SH_W'(1));
   assign w_acc_next = r_acc + (r_b[0] ? r_mcand : '0);

   alu_single #(.W(W)) u_single (
      .i_op       (w_op),
      .i_a        (i_in_a),
      .i_b        (i_in_b),
      .i_in0      (i_in_0),
      .i_immed    (i_immed),
      .i_sc_in    (i_sc_in),
      .o_rslt     (w_s_rslt),
      .o_sc_o     (w_s_sc_o),
      .o_notequal (w_s_ne),
      .o_lessthan (w_s_lt)
   );

   // One shift step in the latched direction, shifting in the latched fill.
   always_comb begin
      w_sh_val = {r_a[W-2:0], r_fill};
      w_sh_out = r_a[W-1];
      if (r_op == OP_SHR) begin
         w_sh_val = {r_fill, r_a[W-1:1]};
         w_sh_out = r_a[0];
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state: launch iterative ops from IDLE, return after the last step.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (i_start && w_launch) w_state_next = RUN;
         RUN:     if (w_last)              w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      o_busy = (r_state == RUN);
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_op       <= OP_PAR;
         r_count    <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_mcand    <= '0;
         r_acc      <= '0;
         r_fill     <= 1'b0;
         r_done     <= 1'b0;
         r_rslt     <= '0;
         r_sc_o     <= 1'b0;
         r_notequal <= 1'b0;
         r_lessthan <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == IDLE) begin
            if (i_start) begin
               r_op    <= w_op;
               r_a     <= i_in_a;
               r_b     <= i_in_b;
               r_mcand <= {{W{1'b0}}, i_in_a};
               r_acc   <= '0;
               r_fill  <= i_sc_in;
               if (w_launch) begin
                  r_count <= (w_op == OP_MUL) ? W_SH : w_k;
               end else begin
                  r_rslt     <= w_s_rslt;
                  r_sc_o     <= w_s_sc_o;
                  r_notequal <= w_s_ne;
                  r_lessthan <= w_s_lt;
                  r_done     <= 1'b1;
               end
            end
         end else begin
            r_count <= r_count - SH_W'(1);
            if (r_op == OP_MUL) begin
               r_acc   <= w_acc_next;
               r_mcand <= r_mcand << 1;
               r_b     <= r_b >> 1;
            end else begin
               r_a <= w_sh_val;
            end
            if (w_last) begin
               r_done     <= 1'b1;
               r_notequal <= 1'b0;
               r_lessthan <= 1'b0;
               if (r_op == OP_MUL) begin
                  r_rslt <= w_acc_next[W-1:0];
                  r_sc_o <= |w_acc_next[2*W-1:W];
               end else begin
                  r_rslt <= w_sh_val;
                  r_sc_o <= w_sh_out;
               end
            end
         end
      end
   end

   assign o_done     = r_done;
   assign o_rslt     = r_rslt;
   assign o_sc_o     = r_sc_o;
   assign o_notequal = r_notequal;
   assign o_lessthan = r_lessthan;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu (W=8): hand-computed results and cycle timing.
module tb_iter_alu;

   localparam logic [2:0] PAR = 3'b000, SHL = 3'b001, SHR = 3'b010, CMP = 3'b011;
   localparam logic [2:0] HSET = 3'b100, AND_ = 3'b101, MUL = 3'b110, ADD = 3'b111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] in_a = '0, in_b = '0, in_0 = '0;
   logic [3:0] immed = '0;
   logic       sc_in = 1'b0;
   logic       busy, done, sc_o, notequal, lessthan;
   logic [7:0] rslt;

   int checks = 0;
   int errors = 0;

   iter_alu #(.W(8)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_op       (op),
      .i_in_a     (in_a),
      .i_in_b     (in_b),
      .i_in_0     (in_0),
      .i_immed    (immed),
      .i_sc_in    (sc_in),
      .o_busy     (busy),
      .o_done     (done),
      .o_rslt     (rslt),
      .o_sc_o     (sc_o),
      .o_notequal (notequal),
      .o_lessthan (lessthan)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one start cycle (cycle 0) and return in cycle 1 with the operands scrambled.
   task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] z, input logic [3:0] imm, input logic sc);
      op = o; in_a = a; in_b = b; in_0 = z; immed = imm; sc_in = sc;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_a = ~a; in_b = ~b; in_0 = ~z; immed = ~imm; sc_in = ~sc; op = ~o;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({busy, done, rslt, sc_o, notequal, lessthan} !== 13'h0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b rslt=%h sc=%b ne=%b lt=%b required all 0",
                  busy, done, rslt, sc_o, notequal, lessthan);
      end
      $display("reset: busy=%b done=%b rslt=%h", busy, done, rslt);
   endtask

   task automatic test_add();
      issue(ADD, 8'hFF, 8'h01, 8'h00, 4'h0, 1'b0);
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL add_carry: got done=%b rslt=%h sc=%b required 1 00 1", done, rslt, sc_o);
      end
      $display("ADD FF+01: done=%b rslt=%h sc=%b", done, rslt, sc_o);
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL add_done_pulse: got done=%b required 0", done);
      end
      issue(ADD, 8'h12, 8'h34, 8'h00, 4'h0, 1'b1);
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'h47, 1'b0}) begin
         errors++;
         $display("FAIL add_cin: got done=%b rslt=%h sc=%b required 1 47 0", done, rslt, sc_o);
      end
      $display("ADD 12+34+1: done=%b rslt=%h sc=%b", done, rslt, sc_o);
   endtask

   task automatic test_single();
      issue(PAR, 8'h07, 8'h00, 8'h00, 4'h0, 1'b1);
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'h01, 1'b0}) begin
         errors++;
         $display("FAIL par: got done=%b rslt=%h sc=%b required 1 01 0", done, rslt, sc_o);
      end
      $display("PAR 07: rslt=%h sc=%b", rslt, sc_o);
      issue(AND_, 8'hF0, 8'h3C, 8'h00, 4'h0, 1'b0);
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'h30, 1'b0}) begin
         errors++;
         $display("FAIL and: got done=%b rslt=%h sc=%b required 1 30 0", done, rslt, sc_o);
      end
      $display("AND F0&3C: rslt=%h", rslt);
      issue(HSET, 8'h00, 8'h00, 8'hAB, 4'h5, 1'b1);
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'hB5, 1'b0}) begin
         errors++;
         $display("FAIL halfset: got done=%b rslt=%h sc=%b required 1 B5 0", done, rslt, sc_o);
      end
      $display("HALFSET AB/5: rslt=%h", rslt);
   endtask

   task automatic test_shl();
      issue(SHL, 8'h81, 8'h03, 8'h00, 4'h0, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL shl_busy_c%0d: got busy=%b done=%b required 1 0", c, busy, done);
         end
         tick();
      end
      checks++;
      if ({busy, done, rslt, sc_o} !== {1'b0, 1'b1, 8'h0F, 1'b0}) begin
         errors++;
         $display("FAIL shl_result: got busy=%b done=%b rslt=%h sc=%b required 0 1 0F 0",
                  busy, done, rslt, sc_o);
      end
      $display("SHL 81<<3 fill1: rslt=%h sc=%b", rslt, sc_o);
   endtask

   task automatic test_shr();
      issue(SHR, 8'hA5, 8'h0C, 8'h00, 4'h0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL shr_busy_c%0d: got busy=%b done=%b required 1 0", c, busy, done);
         end
         tick();
      end
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL shr_clamp: got done=%b rslt=%h sc=%b required 1 00 1", done, rslt, sc_o);
      end
      $display("SHR A5>>12(8): rslt=%h sc=%b", rslt, sc_o);
      issue(SHR, 8'hA5, 8'h00, 8'h00, 4'h0, 1'b1);
      checks++;
      if ({busy, done, rslt, sc_o} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
         errors++;
         $display("FAIL shr_zero: got busy=%b done=%b rslt=%h sc=%b required 0 1 A5 0",
                  busy, done, rslt, sc_o);
      end
      $display("SHR A5>>0: rslt=%h sc=%b", rslt, sc_o);
   endtask

   task automatic test_back_to_back();
      issue(MUL, 8'h10, 8'h11, 8'h00, 4'h0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul1_busy_c%0d: got busy=%b done=%b required 1 0", c, busy, done);
         end
         tick();
      end
      checks++;
      if ({busy, done, rslt, sc_o} !== {1'b0, 1'b1, 8'h10, 1'b1}) begin
         errors++;
         $display("FAIL mul1_result: got busy=%b done=%b rslt=%h sc=%b required 0 1 10 1",
                  busy, done, rslt, sc_o);
      end
      $display("MUL 10*11: rslt=%h sc=%b", rslt, sc_o);
      issue(MUL, 8'h0F, 8'h03, 8'h00, 4'h0, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul2_busy_c%0d: got busy=%b done=%b required 1 0", c, busy, done);
         end
         tick();
      end
      checks++;
      if ({done, rslt, sc_o} !== {1'b1, 8'h2D, 1'b0}) begin
         errors++;
         $display("FAIL mul2_result: got done=%b rslt=%h sc=%b required 1 2D 0", done, rslt, sc_o);
      end
      $display("MUL 0F*03 back-to-back: rslt=%h sc=%b", rslt, sc_o);
   endtask

   task automatic test_cmp_ignore_start();
      int n_done;
      issue(CMP, 8'h03, 8'h07, 8'h00, 4'h0, 1'b1);
      checks++;
      if ({done, rslt, sc_o, notequal, lessthan} !== {1'b1, 8'h00, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL cmp: got done=%b rslt=%h sc=%b ne=%b lt=%b required 1 00 0 1 1",
                  done, rslt, sc_o, notequal, lessthan);
      end
      $display("CMP 03?07: ne=%b lt=%b", notequal, lessthan);
      // SHL 0x01 by 2, start held high through both busy cycles.
      op = SHL; in_a = 8'h01; in_b = 8'h02; sc_in = 1'b0;
      start = 1'b1;
      tick();
      tick();
      tick();
      start = 1'b0;
      checks++;
      if ({busy, done, rslt, sc_o, notequal, lessthan} !== {1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL shl_flags_clear: got busy=%b done=%b rslt=%h sc=%b ne=%b lt=%b required 0 1 04 0 0 0",
                  busy, done, rslt, sc_o, notequal, lessthan);
      end
      $display("SHL 01<<2 with held start: rslt=%h ne=%b lt=%b", rslt, notequal, lessthan);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL held_start_extra: got %0d extra busy/done cycles required 0", n_done);
      end
   endtask

   task automatic test_mul_reset();
      int n_done;
      issue(AND_, 8'hFF, 8'hFF, 8'h00, 4'h0, 1'b0);
      issue(MUL, 8'h05, 8'h05, 8'h00, 4'h0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, done, rslt, sc_o, notequal, lessthan} !== 13'h0) begin
         errors++;
         $display("FAIL mul_reset: got busy=%b done=%b rslt=%h sc=%b ne=%b lt=%b required all 0",
                  busy, done, rslt, sc_o, notequal, lessthan);
      end
      $display("MUL 05*05 reset at cycle 3: busy=%b done=%b rslt=%h", busy, done, rslt);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL mul_reset_late_done: got %0d busy/done cycles required 0", n_done);
      end
      // Reset wins over a simultaneous start.
      op = ADD; in_a = 8'h01; in_b = 8'h01; sc_in = 1'b0;
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      checks++;
      if ({done, rslt} !== {1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_priority: got done=%b rslt=%h required 0 00", done, rslt);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_add();
      test_single();
      test_shl();
      test_shr();
      test_back_to_back();
      test_cmp_ignore_start();
      test_mul_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_alu.md
# iter_alu

Multi-cycle, parametrised successor to the datapath's single-cycle ALU. Captures operands on a `start` strobe and runs single-cycle ops (parity, add, AND, compare, halfset) or iterative ops (multi-bit shifts, shift-add multiply). Returns registered results with a one-cycle `done` pulse. Sits between the register file read ports and the writeback/branch logic; the controller stalls on `busy`.

## Interface
- `W`, 8: datapath width; must be even and ≥4.
- `SH_W`, `$clog2(W)+1`: width of the shift-amount field taken from `inB[SH_W-1:0]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: operation code (`alu_op_t`).
- `inA`, `inB`, `in0` in W: operands.
- `immed` in W/2: halfset immediate.
- `sc_in` in 1: carry/fill in.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when results are valid.
- `rslt` out W: registered result.
- `sc_o` out 1: registered carry/shift-out/overflow.
- `notequal`, `lessthan` out 1: registered branch flags.

## Operation
- Ops:
  - 000 PAR: `rslt={0,^inA}`.
  - 001 SHL: fill `sc_in`; `sc_o` = last bit shifted out.
  - 010 SHR: fill `sc_in`; `sc_o` = last bit shifted out.
  - 011 CMP: `notequal=(A!=B)`, `lessthan=(A<B)` unsigned, `rslt=0`.
  - 100 HALFSET: `rslt={in0[W/2-1:0],immed}`.
  - 101 AND: `rslt=A&B`.
  - 110 MUL: unsigned shift-add; `rslt` = low W bits of the product, `sc_o` = OR of the high W bits (overflow).
  - 111 ADD: `{sc_o,rslt}=A+B+sc_in`.
- FSM has two states, IDLE and RUN.
- IDLE with `start`:
  - Operands, op and `sc_in` are latched.
  - Single-cycle ops write their results and stay in IDLE.
  - SHL/SHR with amount k≥1 go to RUN with count=k.
  - MUL goes to RUN with count=W.
- Shift amount: k = `inB[SH_W-1:0]`, clamped to W. k=0 returns `rslt=inA`, `sc_o=0` as a single-cycle op.
- RUN: one shift or one multiply step per cycle and count decrements. At count=1 the final step is written, the FSM returns to IDLE and `done` is set.
- Every completing op writes all four outputs. Flags not produced by the op are cleared to 0. `sc_o`=0 for PAR, CMP, HALFSET and AND.
- Outputs hold their values until the next op completes.
- `start` while in RUN is ignored; there is no queueing.

## Timing
- Reset (any cycle, including mid-RUN): next cycle state=IDLE, `busy`=0, `done`=0, `rslt`=0, `sc_o`=0, `notequal`=0, `lessthan`=0, count=0. An in-flight op is discarded.
- `start` sampled in cycle 0:
  - Single-cycle ops: `done` in cycle 1.
  - Shift by k≥1: `busy` in cycles 1..k, `done` in cycle k+1.
  - MUL: `busy` in cycles 1..W, `done` in cycle W+1.
- `done` is high for exactly one cycle. The FSM is IDLE in the `done` cycle, so a back-to-back `start` in that cycle is accepted.
- Operand inputs may change after the start cycle without effect.
- `reset` has priority over `start`.

## Structure
- `iter_alu_pkg`: `alu_op_t` enum (the 8 codes above) and `state_t` enum {IDLE, RUN}.
- Sub-module `alu_single`: combinational evaluation of PAR/CMP/HALFSET/AND/ADD, parametrised by W, instantiated once.
- Top-level holds the FSM, counter, operand/accumulator registers, shift/multiply step and output registers.

## Test plan
- Assert reset for 1 cycle at cycle 3 of a MUL -> cycle 4: `busy`=0, `done`=0, `rslt`=0x00, flags 0; no later `done`.
- ADD A=0xFF, B=0x01, `sc_in`=0 at cycle 0 -> cycle 1: `done`=1, `rslt`=0x00, `sc_o`=1; `done`=0 in cycle 2.
- SHL A=0x81, B=3, `sc_in`=1 -> `busy` in cycles 1-3; cycle 4: `done`, `rslt`=0x0F, `sc_o`=0.
- SHR A=0xA5, B=12 (clamped to 8), `sc_in`=0 -> cycle 9: `rslt`=0x00, `sc_o`=1. SHR A=0xA5, B=0 -> cycle 1: `rslt`=0xA5, `sc_o`=0.
- MUL checks:
  - 0x10×0x11 -> cycle 9: `rslt`=0x10, `sc_o`=1.
  - Back-to-back MUL 0x0F×0x03 issued in the `done` cycle -> 9 cycles later: `rslt`=0x2D, `sc_o`=0.
- CMP A=0x03, B=0x07 -> cycle 1: `notequal`=1, `lessthan`=1.
  - Then SHL by 2 with an extra `start` held high during `busy` -> only one `done`, and the flags clear to 0 at that completion.
